// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for knight's-tour playback and command arbitration.
// Command word layout is {opcode, heading, squares}.
package tour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_WAIT_V,
        ST_HORZ,
        ST_WAIT_H
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_POS = 8'h5A;

    localparam int IDX_W = 5;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

    function automatic cmd_t mk_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                    input logic [3:0] sq);
        cmd_t c;
        c.opcode  = op;
        c.heading = hdg;
        c.squares = sq;
        return c;
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Solver, UART and command-processor signals seen by the tour sequencer.
// master = sequencer side, slave = surrounding system.
interface tour_cmd_if;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        input  move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

    modport slave (
        output move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_move_dec.sv
// One-hot knight move -> vertical leg (plain move) and horizontal leg (fanfare).
// Purely combinational; o_valid low for zero or multi-bit input.
module tour_move_dec
    import tour_pkg::*;
(
    input  logic [7:0]  i_move,
    output logic [15:0] o_vert_cmd,
    output logic [15:0] o_horz_cmd,
    output logic        o_valid
);

    logic [7:0] w_vhdg;
    logic [3:0] w_vsq;
    logic [7:0] w_hhdg;
    logic [3:0] w_hsq;
    logic       w_valid;

    always_comb begin
        w_vhdg  = HDG_N;
        w_vsq   = 4'd0;
        w_hhdg  = HDG_E;
        w_hsq   = 4'd0;
        w_valid = 1'b1;
        case (i_move)
            8'h01: begin w_vhdg = HDG_N; w_vsq = 4'd2; w_hhdg = HDG_W; w_hsq = 4'd1; end
            8'h02: begin w_vhdg = HDG_N; w_vsq = 4'd2; w_hhdg = HDG_E; w_hsq = 4'd1; end
            8'h04: begin w_vhdg = HDG_N; w_vsq = 4'd1; w_hhdg = HDG_W; w_hsq = 4'd2; end
            8'h08: begin w_vhdg = HDG_S; w_vsq = 4'd1; w_hhdg = HDG_W; w_hsq = 4'd2; end
            8'h10: begin w_vhdg = HDG_S; w_vsq = 4'd2; w_hhdg = HDG_W; w_hsq = 4'd1; end
            8'h20: begin w_vhdg = HDG_S; w_vsq = 4'd2; w_hhdg = HDG_E; w_hsq = 4'd1; end
            8'h40: begin w_vhdg = HDG_N; w_vsq = 4'd1; w_hhdg = HDG_E; w_hsq = 4'd2; end
            8'h80: begin w_vhdg = HDG_S; w_vsq = 4'd1; w_hhdg = HDG_E; w_hsq = 4'd2; end
            default: w_valid = 1'b0;
        endcase
    end

    assign o_vert_cmd = mk_cmd(OP_MOVE, w_vhdg, w_vsq);
    assign o_horz_cmd = mk_cmd(OP_FANFARE, w_hhdg, w_hsq);
    assign o_valid    = w_valid;

endmodule

// File: rtl/tour_cmd.sv
// Plays back a solved knight's tour as vertical+horizontal legs, else passes UART commands through.
// cmd/cmd_rdy combinational from state; each leg held until clr_cmd_rdy, next leg after send_resp.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_tour,
    tour_cmd_if.master bus,
    output logic       tour_busy,
    output logic       tour_done,
    output logic       tour_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [IDX_W-1:0] r_mv_indx;
    logic [IDX_W-1:0] w_nxt_indx;
    logic             r_tour_done;
    logic             r_tour_err;
    logic             w_done;
    logic             w_err;

    logic [15:0]      w_vert_cmd;
    logic [15:0]      w_horz_cmd;
    logic             w_valid;
    logic             w_last;

    logic [15:0]      w_cmd;
    logic             w_cmd_rdy;
    logic             w_clr_uart;
    logic [7:0]       w_resp;
    logic             w_busy;

    tour_move_dec u_dec (
        .i_move     (bus.move),
        .o_vert_cmd (w_vert_cmd),
        .o_horz_cmd (w_horz_cmd),
        .o_valid    (w_valid)
    );

    assign w_last = (r_mv_indx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mv_indx   <= '0;
            r_tour_done <= 1'b0;
            r_tour_err  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_mv_indx   <= w_nxt_indx;
            r_tour_done <= w_done;
            r_tour_err  <= w_err;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_indx  = r_mv_indx;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cmd       = bus.cmd_UART;
        w_cmd_rdy   = bus.cmd_rdy_UART;
        w_clr_uart  = bus.clr_cmd_rdy;
        w_resp      = RESP_ACK;
        w_busy      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_tour) begin
                    w_nxt_state = ST_VERT;
                    w_nxt_indx  = '0;
                end
            end
            ST_VERT: begin
                w_cmd      = w_vert_cmd;
                w_cmd_rdy  = w_valid;
                w_clr_uart = 1'b0;
                w_resp     = RESP_POS;
                w_busy     = 1'b1;
                // A corrupt solver entry aborts the tour before anything is issued
                if (!w_valid) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_indx  = '0;
                    w_err       = 1'b1;
                end else if (bus.clr_cmd_rdy) begin
                    w_nxt_state = ST_WAIT_V;
                end
            end
            ST_WAIT_V: begin
                w_cmd      = w_vert_cmd;
                w_cmd_rdy  = 1'b0;
                w_clr_uart = 1'b0;
                w_resp     = RESP_POS;
                w_busy     = 1'b1;
                if (bus.send_resp) begin
                    w_nxt_state = ST_HORZ;
                end
            end
            ST_HORZ: begin
                w_cmd      = w_horz_cmd;
                w_cmd_rdy  = 1'b1;
                w_clr_uart = 1'b0;
                w_resp     = RESP_POS;
                w_busy     = 1'b1;
                if (bus.clr_cmd_rdy) begin
                    w_nxt_state = ST_WAIT_H;
                end
            end
            ST_WAIT_H: begin
                w_cmd      = w_horz_cmd;
                w_cmd_rdy  = 1'b0;
                w_clr_uart = 1'b0;
                w_resp     = w_last ? RESP_ACK : RESP_POS;
                w_busy     = 1'b1;
                if (bus.send_resp) begin
                    if (w_last) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_indx  = '0;
                        w_done      = 1'b1;
                    end else begin
                        w_nxt_state = ST_VERT;
                        w_nxt_indx  = r_mv_indx + 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_indx  = '0;
            end
        endcase
    end

    assign bus.mv_indx          = r_mv_indx;
    assign bus.cmd              = w_cmd;
    assign bus.cmd_rdy          = w_cmd_rdy;
    assign bus.clr_cmd_rdy_UART = w_clr_uart;
    assign bus.resp             = w_resp;
    assign tour_busy            = w_busy;
    assign tour_done            = r_tour_done;
    assign tour_err             = r_tour_err;

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Sequences playback of a solved knight's tour and arbitrates the motion-command channel between the UART command path and tour playback. After the tour solver completes, `tour_cmd` steps the solver's move index from 0 to NUM_MOVES-1. It decodes each one-hot move into two motion commands: a vertical leg first, then a horizontal leg with fanfare. It issues each command over the same `cmd`/`cmd_rdy`/`clr_cmd_rdy` handshake the command processor already consumes. When no tour is playing, UART commands pass straight through.

## Interface
- NUM_MOVES, 24, number of moves played back; final index is NUM_MOVES-1
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- start_tour  in  1  one-cycle pulse: begin playback (solver `done` already seen)
- move  in  8  one-hot move read from the solver at `mv_indx`, combinational
- mv_indx  out  5  move index presented to the solver
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  ack to the UART wrapper
- cmd  out  16  command to the command processor: {opcode[3:0], heading[7:0], squares[3:0]}
- cmd_rdy  out  1  `cmd` valid
- clr_cmd_rdy  in  1  command processor accepted `cmd`
- send_resp  in  1  command processor finished executing the current command
- resp  out  8  response byte the UART returns to the host
- tour_busy  out  1  high while playback owns the channel
- tour_done  out  1  one-cycle pulse when the last leg completes
- tour_err  out  1  one-cycle pulse on a non-one-hot `move`

## Operation
- **Move decode, (dx, dy) per bit:**
  - b0 (-1,+2), b1 (+1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,+1), b7 (+2,-1)
- **Directions:** +y = north, heading 8'h00; -y = south, 8'h7F; -x = west, 8'h3F; +x = east, 8'hBF.
- **Vertical leg:** opcode 4'h2 (move), squares = |dy|.
- **Horizontal leg:** opcode 4'h3 (move with fanfare), squares = |dx|.
- **States:**
  - IDLE → VERT on `start_tour`; `mv_indx` ← 0.
  - VERT: `cmd` = vertical leg, `cmd_rdy`=1. Stay until `clr_cmd_rdy`, then go to WAIT_V.
  - WAIT_V: `cmd_rdy`=0. Stay until `send_resp`, then go to HORZ.
  - HORZ: `cmd` = horizontal leg, `cmd_rdy`=1. Stay until `clr_cmd_rdy`, then go to WAIT_H.
  - WAIT_H: stay until `send_resp`.
    - If `mv_indx`==NUM_MOVES-1: go to IDLE and pulse `tour_done`.
    - Otherwise: `mv_indx`++ and go to VERT.
- **Mux:**
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`, `resp`=8'hA5.
  - Any other state: `clr_cmd_rdy_UART`=0 and `tour_busy`=1.
- **resp during tour:** 8'h5A, except 8'hA5 in WAIT_H when `mv_indx`==NUM_MOVES-1.
- **Boundary conditions:**
  - `start_tour` outside IDLE is ignored.
  - `send_resp` in VERT or HORZ is ignored; completion counts only after acceptance.
  - `clr_cmd_rdy` in a WAIT state is ignored.
  - In VERT, if `move` is not one-hot (zero or multi-bit): pulse `tour_err`, go to IDLE, set `mv_indx` to 0, issue no command.
  - Simultaneous `clr_cmd_rdy` and `send_resp` in VERT: take only the VERT → WAIT_V transition; that `send_resp` is not counted.
  - `rst_n` low at any time, mid-tour included: next edge forces IDLE, `mv_indx`=0; the tour is abandoned, not resumed.

## Timing
- Reset values: state IDLE; `mv_indx`=0; `tour_busy`=0; `cmd_rdy`=0 (pass-through value follows `cmd_rdy_UART`); `tour_done`=0; `tour_err`=0; `resp`=8'hA5.
- `start_tour` at edge N → `cmd_rdy`=1 with the move-0 vertical leg in cycle N+1.
- `cmd_rdy` falls the cycle after `clr_cmd_rdy` is sampled.
- Next leg's `cmd_rdy` rises the cycle after `send_resp` is sampled.
- `move` is read combinationally; `mv_indx` is registered, so `move` is valid in the same cycle.
- `cmd`, `cmd_rdy`, `resp` are combinational from state, `mv_indx` and `move`. `tour_done` and `tour_err` are registered one-cycle pulses.
- Minimum per move: 4 cycles plus consumer latency.

## Structure
- Package `tour_pkg` holds:
  - state enum;
  - opcodes `OP_MOVE`=4'h2 and `OP_FANFARE`=4'h3;
  - headings `HDG_N`/`HDG_W`/`HDG_S`/`HDG_E`;
  - response bytes `RESP_ACK`=8'hA5 and `RESP_POS`=8'h5A.
- Sub-module `tour_move_dec` is combinational: `move` → {vert_cmd[15:0], horz_cmd[15:0], valid}. The same decode serves the solver's verification model.

## Test plan
- Pass-through: IDLE, `cmd_UART`=16'h2001, `cmd_rdy_UART`=1, `clr_cmd_rdy` pulse → `cmd`=16'h2001, `cmd_rdy`=1, `clr_cmd_rdy_UART` pulses, `resp`=8'hA5.
- Decode b0 and b7:
  - `move`=8'h01 → VERT `cmd`=16'h2002, HORZ `cmd`=16'h33F1.
  - `move`=8'h80 → 16'h27F1, then 16'h3BF2.
- Full tour: 24 moves, consumer model with random 1-20 cycle ack/response latency.
  - `mv_indx` steps 0..23 once each, 48 commands issued.
  - `resp`=8'h5A throughout, 8'hA5 on the final leg.
  - `tour_done` pulses once.
- Handshake abuse: `send_resp` before `clr_cmd_rdy`; `start_tour` mid-tour; simultaneous `clr_cmd_rdy`+`send_resp` → all ignored as specified, no skipped or duplicated leg.
- `move`=8'h03 at `mv_indx`=5 → `tour_err` pulse, IDLE, `mv_indx`=0, `cmd_rdy` never asserted for it.
- `rst_n` low for 1 cycle during WAIT_H at `mv_indx`=10 → IDLE, `mv_indx`=0, `tour_busy`=0 next cycle; a new `start_tour` restarts from move 0.
